// File: rtl/uart_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_defs_pkg
// Description : Definitions shared by the UART transmitter and receiver:
//               frame FSM state encodings and bit-period arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_defs_pkg;

  // Frame FSM state encodings (also used by the receiver)
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Clock cycles per line bit; integer division truncates toward zero
  function automatic int bit_ticks(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : Synchronous single-clock FIFO. A push while full and a pop
//               while empty are ignored. Full/empty come from the registered
//               occupancy count only.
// Ports       : clk, reset (sync, active high), push_i, pop_i, data_i,
//               data_o (head entry), full_o, empty_o
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_push, w_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (w_push && !reset) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffered
// Description : 8N1 UART transmitter fed by a byte FIFO. Frames are sent
//               back to back without idle gaps while txEn is high.
// Ports       : clk, reset (sync, active high), txEn (gates new frames),
//               txStart (push strobe), txIn[7:0] (byte to queue),
//               txOut (serial line, idles high), txBusy (frame on line),
//               txDone (last stop-bit cycle), txFull (FIFO full),
//               txErr (dropped-write pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
  import uart_defs_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txOut,
  output logic       txBusy,
  output logic       txDone,
  output logic       txFull,
  output logic       txErr
);

  localparam int BIT_TICKS = bit_ticks(CLOCK_RATE, BAUD_RATE);
  localparam int TICK_W    = cnt_width(BIT_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);

  logic [1:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q,  tick_d;
  logic [2:0]        bit_q,   bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txOut_q, txOut_d;
  logic              txErr_q;

  logic              w_pop, w_empty, w_tick_end, w_can_start;
  logic [7:0]        w_head;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (txStart),
    .pop_i   (w_pop),
    .data_i  (txIn),
    .data_o  (w_head),
    .full_o  (txFull),
    .empty_o (w_empty)
  );

  assign w_tick_end  = (tick_q == TICK_LAST);
  assign w_can_start = txEn && !w_empty;

  always_comb begin
    state_d = state_q;
    tick_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    txOut_d = txOut_q;
    w_pop   = 1'b0;
    if (state_q != IDLE)
      tick_d = w_tick_end ? '0 : tick_q + TICK_W'(1);
    case (state_q)
      IDLE: begin
        if (w_can_start) begin
          state_d = START;
          w_pop   = 1'b1;
          shift_d = w_head;
          txOut_d = 1'b0;
        end
      end
      START: begin
        if (w_tick_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          txOut_d = shift_q[0];
        end
      end
      DATA: begin
        if (w_tick_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txOut_d = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            // next data bit goes out straight from the pre-shift value
            txOut_d = shift_q[1];
          end
        end
      end
      STOP: begin
        if (w_tick_end) begin
          // chaining straight into START removes any inter-frame gap
          if (w_can_start) begin
            state_d = START;
            w_pop   = 1'b1;
            shift_d = w_head;
            txOut_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txOut_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txOut_q <= 1'b1;
      txErr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txOut_q <= txOut_d;
      // full is the registered count, so a same-cycle pop does not save it
      txErr_q <= txStart && txFull;
    end
  end

  assign txOut  = txOut_q;
  assign txBusy = (state_q != IDLE);
  assign txDone = (state_q == STOP) && w_tick_end;
  assign txErr  = txErr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buffered
// Description : Directed self-checking bench for uart_tx_buffered. Uses
//               165 Hz / 10 baud so the bit period truncates to 16 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

  localparam int BT    = 16;       // 165 / 10 truncated
  localparam int FRAME = 10 * BT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       txEn = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] txIn = 8'h00;
  logic       txOut, txBusy, txDone, txFull, txErr;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_buffered #(
    .CLOCK_RATE (165),
    .BAUD_RATE  (10),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .txEn    (txEn),
    .txStart (txStart),
    .txIn    (txIn),
    .txOut   (txOut),
    .txBusy  (txBusy),
    .txDone  (txDone),
    .txFull  (txFull),
    .txErr   (txErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one write strobe; returns #1 after the edge that samples it
  task automatic push(input logic [7:0] d);
    @(negedge clk);
    txStart = 1'b1;
    txIn    = d;
    @(posedge clk);
    #1;
    txStart = 1'b0;
    txIn    = 8'hXX;
  endtask

  // Watch one frame whose start bit falls on the next rising edge.
  // Decodes it like a receiver (mid-bit sampling) and checks the waveform.
  task automatic check_frame(input logic [7:0] d);
    logic [9:0] exp_bits;
    logic [9:0] bad_bits;
    logic [7:0] rx;
    logic       stop_s;
    int         done_cnt, done_at, busy_bad, b;
    exp_bits = {1'b1, d, 1'b0};
    bad_bits = '0;
    rx       = '0;
    stop_s   = 1'b0;
    done_cnt = 0;
    done_at  = -1;
    busy_bad = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(posedge clk);
      #1;
      b = k / BT;
      if (txOut !== exp_bits[b]) bad_bits[b] = 1'b1;
      if ((k % BT) == BT / 2) begin
        if (b >= 1 && b <= 8) rx[b-1] = txOut;
        if (b == 9) stop_s = txOut;
      end
      if (txDone === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (txBusy !== 1'b1) busy_bad++;
    end
    check("frame_bits", {22'd0, bad_bits}, 32'd0);
    check("rx_byte", {24'd0, rx}, {24'd0, d});
    check("rx_stop", {31'd0, stop_s}, 32'd1);
    check("done_count", done_cnt, 32'd1);
    check("done_cycle", done_at, FRAME - 1);
    check("busy_in_frame", busy_bad, 32'd0);
  endtask

  // Line must stay idle for n cycles
  task automatic check_quiet(input string tag, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (txOut !== 1'b1 || txBusy !== 1'b0) bad++;
    end
    check(tag, bad, 32'd0);
  endtask

  initial begin
    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_txOut", {31'd0, txOut}, 32'd1);
    check("rst_txBusy", {31'd0, txBusy}, 32'd0);
    check("rst_txDone", {31'd0, txDone}, 32'd0);
    check("rst_txFull", {31'd0, txFull}, 32'd0);
    check("rst_txErr", {31'd0, txErr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    txEn  = 1'b1;
    check_quiet("idle_after_rst", 5);

    // ---- single byte: start bit falls on the edge after the write edge
    push(8'hB5);
    check_frame(8'hB5);
    @(posedge clk);
    #1;
    check("single_idle_busy", {31'd0, txBusy}, 32'd0);
    check("single_idle_out", {31'd0, txOut}, 32'd1);

    // ---- burst: fill with txEn low, fifth write is dropped
    @(negedge clk);
    txEn = 1'b0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    check("burst_full", {31'd0, txFull}, 32'd1);
    push(8'h05);
    check("burst_err_pulse", {31'd0, txErr}, 32'd1);
    @(posedge clk);
    #1;
    check("burst_err_clear", {31'd0, txErr}, 32'd0);
    check("burst_still_full", {31'd0, txFull}, 32'd1);
    @(negedge clk);
    txEn = 1'b1;
    check_frame(8'h01);
    check_frame(8'h02);
    check_frame(8'h03);
    check_frame(8'h04);
    check_quiet("burst_no_fifth", 2 * BT);
    check("burst_empty_full", {31'd0, txFull}, 32'd0);

    // ---- enable gating
    @(negedge clk);
    txEn = 1'b0;
    push(8'h55);
    check_quiet("gate_hold", 3 * BT);
    @(negedge clk);
    txEn = 1'b1;
    check_frame(8'h55);

    // ---- reset during data bit 3 of 0xA5 with 0x3C queued
    @(negedge clk);
    txEn = 1'b0;
    push(8'hA5);
    push(8'h3C);
    @(negedge clk);
    txEn = 1'b1;
    for (int k = 0; k <= 4 * BT + 6; k++) begin
      @(posedge clk);
      #1;
    end
    check("mid_data_bit3", {31'd0, txOut}, 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    txStart = 1'b1;       // lost: reset has priority
    txIn    = 8'hFF;
    @(posedge clk);
    #1;
    txStart = 1'b0;
    check("abort_txOut", {31'd0, txOut}, 32'd1);
    check("abort_txFull", {31'd0, txFull}, 32'd0);
    check("abort_txBusy", {31'd0, txBusy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_quiet("no_frame_after_rst", 3 * FRAME / 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
